// File: rtl/rv32_alu_seq.sv
// rv32_alu_seq: single-issue ALU with an optional multi-cycle multiplier.
// Handshaked in/out ports; one result register; a three-state control FSM.
// Single-cycle ops give their result one cycle after accept. Multiplies run
// a radix-2 shift-add loop over WIDTH cycles when RV32_ALU_MUL_EN is defined.
// Without RV32_ALU_MUL_EN there is no multiplier, and mul requests complete in
// one cycle with a zero result.
module rv32_alu_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic             mul,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out
);
    localparam int SH_W = CNT_W - 1;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SLL  = 4'd1;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SRL  = 4'd5;
    localparam logic [3:0] OP_OR   = 4'd6;
    localparam logic [3:0] OP_AND  = 4'd7;
    localparam logic [3:0] OP_SEQ  = 4'd8;
    localparam logic [3:0] OP_SNE  = 4'd9;
    localparam logic [3:0] OP_SUB  = 4'd10;
    localparam logic [3:0] OP_SRA  = 4'd11;
    localparam logic [3:0] OP_SLT  = 4'd12;
    localparam logic [3:0] OP_SGE  = 4'd13;
    localparam logic [3:0] OP_SLTU = 4'd14;
    localparam logic [3:0] OP_SGEU = 4'd15;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MUL_RUN = 2'd1,
        HOLD    = 2'd2
    } state_t;

    state_t state;
    logic   accept;

    // A new request can enter when nothing is held, or when the held result
    // leaves in the same cycle. Reset forces the port closed.
    assign in_ready = reset_n && ((state == IDLE) || (state == HOLD && out_ready));
    assign accept   = in_valid && in_ready;

    // ------------------------------------------------------------------
    // Single-cycle ALU
    // ------------------------------------------------------------------
    logic [SH_W-1:0]  shamt;
    logic [WIDTH-1:0] alu_res;
    logic             eq;
    logic             lt_s;
    logic             lt_u;

    // Combinational result of the non-multiply operations
    always_comb begin
        shamt   = in2[SH_W-1:0];
        eq      = (in1 == in2);
        lt_s    = ($signed(in1) < $signed(in2));
        lt_u    = (in1 < in2);
        alu_res = '0;
        case (op)
            OP_ADD:  alu_res = in1 + in2;
            OP_SLL:  alu_res = in1 << shamt;
            OP_XOR:  alu_res = in1 ^ in2;
            OP_SRL:  alu_res = in1 >> shamt;
            OP_OR:   alu_res = in1 | in2;
            OP_AND:  alu_res = in1 & in2;
            OP_SEQ:  alu_res = {{(WIDTH-1){1'b0}}, eq};
            OP_SNE:  alu_res = {{(WIDTH-1){1'b0}}, ~eq};
            OP_SUB:  alu_res = in1 - in2;
            OP_SRA:  alu_res = $signed(in1) >>> shamt;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, lt_s};
            OP_SGE:  alu_res = {{(WIDTH-1){1'b0}}, ~lt_s};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, lt_u};
            OP_SGEU: alu_res = {{(WIDTH-1){1'b0}}, ~lt_u};
            default: alu_res = '0;  // codes 2 and 3 are undefined
        endcase
    end

`ifdef RV32_ALU_MUL_EN
    // ------------------------------------------------------------------
    // Shift-add multiplier: magnitudes are multiplied unsigned, and the
    // full product is negated at the end when the operand signs differ.
    // mc_p holds {partial sum, remaining multiplier bits}.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0]   mc_a;
    logic [2*WIDTH-1:0] mc_p;
    logic [CNT_W-1:0]   mc_cnt;
    logic               mc_neg;
    logic               mc_hi;
    logic               mc_last;

    logic               a_sgn;
    logic               b_sgn;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH:0]     step_sum;
    logic [2*WIDTH-1:0] step_p;
    logic [2*WIDTH-1:0] fin_p;
    logic [WIDTH-1:0]   mul_res;

    // Operand conditioning at accept: MULH signs both, MULHSU signs in1 only.
    // MUL keeps only the low half, which is the same for signed and unsigned.
    always_comb begin
        a_sgn = ((op[1:0] == 2'd1) || (op[1:0] == 2'd2)) && in1[WIDTH-1];
        b_sgn = (op[1:0] == 2'd1) && in2[WIDTH-1];
        a_mag = a_sgn ? -in1 : in1;
        b_mag = b_sgn ? -in2 : in2;
    end

    // One radix-2 step, plus the sign fix-up and half select used on the last step
    always_comb begin
        step_sum = {1'b0, mc_p[2*WIDTH-1:WIDTH]} + {1'b0, mc_a & {WIDTH{mc_p[0]}}};
        step_p   = {step_sum, mc_p[WIDTH-1:1]};
        fin_p    = mc_neg ? -step_p : step_p;
        mul_res  = mc_hi ? fin_p[2*WIDTH-1:WIDTH] : fin_p[WIDTH-1:0];
        mc_last  = (mc_cnt == CNT_W'(WIDTH - 1));
    end
`endif

    // Control FSM with registered result, valid flag and multiplier state
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            out       <= '0;
            out_valid <= 1'b0;
`ifdef RV32_ALU_MUL_EN
            mc_a      <= '0;
            mc_p      <= '0;
            mc_cnt    <= '0;
            mc_neg    <= 1'b0;
            mc_hi     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, HOLD: begin
                    if (accept) begin
                        if (mul) begin
`ifdef RV32_ALU_MUL_EN
                            state     <= MUL_RUN;
                            out_valid <= 1'b0;
                            mc_a      <= a_mag;
                            mc_p      <= {{WIDTH{1'b0}}, b_mag};
                            mc_cnt    <= '0;
                            mc_neg    <= a_sgn ^ b_sgn;
                            mc_hi     <= (op[1:0] != 2'd0);
`else
                            state     <= HOLD;
                            out       <= '0;
                            out_valid <= 1'b1;
`endif
                        end else begin
                            state     <= HOLD;
                            out       <= alu_res;
                            out_valid <= 1'b1;
                        end
                    end else if (state == HOLD && out_ready) begin
                        // Result consumed and nothing new: drop valid, keep value
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                MUL_RUN: begin
`ifdef RV32_ALU_MUL_EN
                    mc_p   <= step_p;
                    mc_cnt <= mc_cnt + CNT_W'(1);
                    if (mc_last) begin
                        state     <= HOLD;
                        out       <= mul_res;
                        out_valid <= 1'b1;
                    end
`else
                    state <= IDLE;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rv32_alu_seq.sv
// Bench for rv32_alu_seq at WIDTH 8, 32 and 64, all running side by side.
// Each width has a transaction-level model that is compared every cycle,
// plus directed vectors with literal expectations.
`timescale 1ns/1ps
module tb_rv32_alu_seq;
`ifdef RV32_ALU_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input int w, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s (W=%0d): got %h, expected %h", name, w, act, exp);
    endtask

    // Reference result from the arithmetic definition of each operation
    function automatic logic [63:0] ref_op(input int w, input bit en, input logic [3:0] op,
                                           input logic m, input logic [63:0] a_in, input logic [63:0] b_in);
        logic [63:0]        mask, a, b, r;
        longint             sa, sb;
        logic signed [127:0] x, y, p;
        int                 sh;
        mask = {64{1'b1}} >> (64 - w);
        a  = a_in & mask;
        b  = b_in & mask;
        sa = longint'(a << (64 - w)) >>> (64 - w);
        sb = longint'(b << (64 - w)) >>> (64 - w);
        sh = int'(b % 64'(w));
        if (m) begin
            if (!en) return 64'd0;
            x = (op[1:0] == 2'd1 || op[1:0] == 2'd2) ? {{64{sa[63]}}, sa} : {64'd0, a};
            y = (op[1:0] == 2'd1) ? {{64{sb[63]}}, sb} : {64'd0, b};
            p = x * y;
            r = (op[1:0] == 2'd0) ? 64'(p) : 64'(p >> w);
            return r & mask;
        end
        case (op)
            4'd0:  r = a + b;
            4'd1:  r = a << sh;
            4'd4:  r = a ^ b;
            4'd5:  r = a >> sh;
            4'd6:  r = a | b;
            4'd7:  r = a & b;
            4'd8:  r = 64'(a == b);
            4'd9:  r = 64'(a != b);
            4'd10: r = a - b;
            4'd11: r = 64'(sa >>> sh);
            4'd12: r = 64'(sa < sb);
            4'd13: r = 64'(sa >= sb);
            4'd14: r = 64'(a < b);
            4'd15: r = 64'(a >= b);
            default: r = 64'd0;
        endcase
        return r & mask;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : u
        localparam int W = (g == 0) ? 8 : (g == 1) ? 32 : 64;
        localparam logic [63:0] ONES = {64{1'b1}} >> (64 - W);
        localparam logic [63:0] MINV = ONES ^ (ONES >> 1);

        logic         rst_n     = 1'b0;
        logic         in_valid  = 1'b0;
        logic         mul       = 1'b0;
        logic         out_ready = 1'b1;
        logic [3:0]   op        = '0;
        logic [W-1:0] in1       = '0;
        logic [W-1:0] in2       = '0;
        logic         in_ready;
        logic         out_valid;
        logic [W-1:0] out;
        bit           fin       = 1'b0;
        bit           chk_en    = 1'b0;

        rv32_alu_seq #(.WIDTH(W)) dut (
            .clk(clk), .reset_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
            .op(op), .mul(mul), .in1(in1), .in2(in2),
            .out_valid(out_valid), .out_ready(out_ready), .out(out)
        );

        // Model: a held result (m_valid/m_out) and a busy countdown for multiplies
        logic        m_valid = 1'b0;
        logic [63:0] m_out   = '0;
        logic [63:0] m_pend  = '0;
        int          m_busy  = 0;
        logic        m_ready;
        assign m_ready = rst_n && (m_busy == 0) && (!m_valid || out_ready);

        always @(posedge clk) begin : model
            logic        v;
            logic [63:0] o, p;
            int          b;
            v = m_valid; o = m_out; p = m_pend; b = m_busy;
            if (!rst_n) begin
                v = 1'b0; o = '0; b = 0;
            end else if (b > 0) begin
                b = b - 1;
                if (b == 0) begin v = 1'b1; o = p; end
            end else if (in_valid && m_ready) begin
                p = ref_op(W, MUL_EN, op, mul, 64'(in1), 64'(in2));
                if (mul && MUL_EN) begin b = W; v = 1'b0; end
                else begin o = p; v = 1'b1; end
            end else if (v && out_ready) begin
                v = 1'b0;
            end
            m_valid <= v; m_out <= o; m_pend <= p; m_busy <= b;
        end

        always @(negedge clk) begin : compare
            #3;
            if (chk_en) begin
                chk("in_ready", W, 64'(in_ready), 64'(m_ready));
                chk("out_valid", W, 64'(out_valid), 64'(m_valid));
                chk("out", W, 64'(out), m_out);
            end
        end

        task automatic drive(input logic v, input logic [3:0] o, input logic m,
                             input logic [63:0] a, input logic [63:0] b);
            in_valid = v; op = o; mul = m; in1 = a[W-1:0]; in2 = b[W-1:0];
        endtask

        // Present one request, release it after the accepting edge, and
        // count cycles until the result shows (bounded)
        task automatic run(input logic [3:0] o, input logic m, input logic [63:0] a,
                           input logic [63:0] b, output int lat);
            drive(1'b1, o, m, a, b);
            @(negedge clk);
            in_valid = 1'b0;
            lat = 1;
            #3;
            while (!out_valid && lat < W + 8) begin
                @(negedge clk);
                #3;
                lat++;
            end
        endtask

        function automatic logic [63:0] pick();
            case ($urandom_range(0, 4))
                0: return 64'd0;
                1: return ONES;
                2: return MINV;
                3: return 64'($urandom_range(0, 70));
                default: return {$urandom, $urandom};
            endcase
        endfunction

        initial begin : stim
            int lat;
            repeat (2) @(negedge clk);
            chk_en = 1'b1;
            #3;
            chk("rst_out", W, 64'(out), 0);
            chk("rst_valid", W, 64'(out_valid), 0);
            chk("rst_ready", W, 64'(in_ready), 0);

            @(negedge clk); rst_n = 1'b1;
            run(4'd0, 1'b0, ONES, 1, lat);
            chk("add_lat", W, lat, 1);
            chk("add_wrap", W, 64'(out), 0);

            @(negedge clk);
            run(4'd11, 1'b0, MINV, ONES, lat);
            chk("sra_fill", W, 64'(out), ONES);

            @(negedge clk);
            run(4'd14, 1'b0, 1, ONES, lat);
            chk("sltu", W, 64'(out), 1);

            @(negedge clk);
            run(4'd1, 1'b1, ONES, ONES, lat);
            chk("mulh_lat", W, lat, MUL_EN ? W + 1 : 1);
            chk("mulh", W, 64'(out), 0);

            @(negedge clk);
            run(4'd3, 1'b1, ONES, ONES, lat);
            chk("mulhu_lat", W, lat, MUL_EN ? W + 1 : 1);
            chk("mulhu", W, 64'(out), MUL_EN ? ONES - 1 : 0);

            // Backpressure: hold ADD result for 5 cycles with SUB waiting
            @(negedge clk); out_ready = 1'b0;
            run(4'd0, 1'b0, 10, 20, lat);
            chk("bp_add", W, 64'(out), 30);
            @(negedge clk);
            drive(1'b1, 4'd10, 1'b0, 5, 7);
            for (int k = 0; k < 5; k++) begin
                #3;
                chk("bp_out", W, 64'(out), 30);
                chk("bp_valid", W, 64'(out_valid), 1);
                chk("bp_ready", W, 64'(in_ready), 0);
                @(negedge clk);
            end
            out_ready = 1'b1;
            @(negedge clk); in_valid = 1'b0;
            #3;
            chk("b2b_sub", W, 64'(out), ONES - 1);
            chk("b2b_valid", W, 64'(out_valid), 1);

            // Reset in the middle of a multiply
            @(negedge clk);
            drive(1'b1, 4'd0, 1'b1, 64'h1234_5678_9abc_def1, 3);
            @(negedge clk); in_valid = 1'b0;
            repeat ((W >= 16) ? 9 : 3) @(negedge clk);
            rst_n = 1'b0;
            @(negedge clk);
            #3;
            chk("abort_out", W, 64'(out), 0);
            chk("abort_valid", W, 64'(out_valid), 0);
            chk("abort_ready", W, 64'(in_ready), 0);
            @(negedge clk); rst_n = 1'b1;
            #3;
            chk("post_rst_ready", W, 64'(in_ready), 1);
            @(negedge clk);
            run(4'd0, 1'b0, 2, 3, lat);
            chk("post_rst_lat", W, lat, 1);
            chk("post_rst_add", W, 64'(out), 5);

            // Random traffic, every op code, random backpressure
            for (int k = 0; k < 300; k++) begin
                @(negedge clk);
                drive(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                      $urandom_range(0, 7) == 0, pick(), pick());
                out_ready = ($urandom_range(0, 3) != 0);
            end
            @(negedge clk);
            in_valid  = 1'b0;
            out_ready = 1'b1;
            repeat (W + 4) @(negedge clk);
            fin = 1'b1;
        end
    end

    initial begin : top
        chk("model_add", 32, ref_op(32, 1'b1, 4'd0, 1'b0, 64'hFFFF_FFFF, 64'd1), 64'd0);
        chk("model_mulh", 32, ref_op(32, 1'b1, 4'd1, 1'b1, 64'hFFFF_FFFF, 64'hFFFF_FFFF), 64'd0);
        chk("model_mulhu", 32, ref_op(32, 1'b1, 4'd3, 1'b1, 64'hFFFF_FFFF, 64'hFFFF_FFFF), 64'hFFFF_FFFE);
        chk("model_mulhsu", 32, ref_op(32, 1'b1, 4'd2, 1'b1, 64'hFFFF_FFFF, 64'd2), 64'hFFFF_FFFF);
        chk("model_sra", 8, ref_op(8, 1'b1, 4'd11, 1'b0, 64'h80, 64'h07), 64'hFF);
        chk("model_mulhu64", 64, ref_op(64, 1'b1, 4'd3, 1'b1, {64{1'b1}}, {64{1'b1}}), 64'hFFFF_FFFF_FFFF_FFFE);
        for (int t = 0; t < 20000; t++) begin
            if (u[0].fin && u[1].fin && u[2].fin) break;
            @(posedge clk);
        end
        if (!(u[0].fin && u[1].fin && u[2].fin)) begin
            n_total++;
            $display("FAIL timeout: stimulus done flags %b%b%b, required 111",
                     u[2].fin, u[1].fin, u[0].fin);
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
